// File: rtl/target_pkg.sv
// Shared types and screen geometry for the target field and its helpers.
package target_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [9:0] coord_x_t;
    typedef logic [8:0] coord_y_t;

    typedef struct packed {
        logic     valid;
        coord_x_t cx;
        coord_y_t cy;
    } target_t;

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    // Operands arrive zero-extended, so the magnitude never wraps.
    function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/target_field_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), shifts left every cycle, feedback into bit 0.
module lfsr16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    logic [15:0] q_reg;
    logic        fb;

    assign fb = q_reg[15] ^ q_reg[13] ^ q_reg[12] ^ q_reg[10];
    assign q  = q_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg <= seed;
        end else begin
            q_reg <= {q_reg[14:0], fb};
        end
    end

endmodule

// File: rtl/target_field.sv
// Target field: N_TGT square targets, one-slot-per-cycle shot scan, saturating score, LFSR respawn.
// Optional: define TARGET_FIELD_MISS_PENALTY_EN so that a miss also costs one point.
module target_field
    import target_pkg::*;
#(
    parameter int          N_TGT         = 4,
    parameter int          TGT_RADIUS    = 16,
    parameter int          SCORE_W       = 8,
    parameter int          RESPAWN_TICKS = 25_000_000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     shot,
    input  logic [9:0]               shoot_x,
    input  logic [8:0]               shoot_y,
    input  logic [9:0]               x,
    input  logic [8:0]               y,
    output logic                     render,
    output logic                     hit,
    output logic                     miss,
    output logic                     busy,
    output logic [SCORE_W-1:0]       score,
    output logic [N_TGT-1:0]         tgt_valid,
    input  logic [$clog2(N_TGT)-1:0] dbg_sel,
    output logic [9:0]               dbg_x,
    output logic [8:0]               dbg_y
);
    localparam int          IDX_W = $clog2(N_TGT);
    localparam int          CNT_W = $clog2(RESPAWN_TICKS + 2);
    localparam logic [10:0] RAD   = 11'(TGT_RADIUS);
    localparam coord_x_t    X_LO  = coord_x_t'(TGT_RADIUS);
    localparam coord_x_t    X_HI  = coord_x_t'(SCREEN_W - TGT_RADIUS);
    localparam coord_y_t    Y_LO  = coord_y_t'(TGT_RADIUS);
    localparam coord_y_t    Y_HI  = coord_y_t'(SCREEN_H - TGT_RADIUS);

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    coord_x_t           sx_reg;
    coord_y_t           sy_reg;
    target_t            tgt_reg [N_TGT];
    logic [SCORE_W-1:0] score_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               hit_reg;
    logic               miss_reg;
    logic               render_reg;

    logic [15:0]        lfsr_q;
    coord_x_t           cand_x;
    coord_y_t           cand_y;
    logic               cand_ok;
    logic               any_free;
    logic [IDX_W-1:0]   free_idx;
    logic               spawn;
    target_t            spawn_tgt;
    target_t            cur_tgt;
    logic               scan_hit;
    logic [N_TGT-1:0]   pix_in;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // Per-slot render test (strict inequality) and valid fan-out.
    generate
        for (genvar gi = 0; gi < N_TGT; gi++) begin : g_slot
            assign tgt_valid[gi] = tgt_reg[gi].valid;
            assign pix_in[gi]    = tgt_reg[gi].valid
                                && (abs_diff({1'b0, x}, {1'b0, tgt_reg[gi].cx}) < RAD)
                                && (abs_diff({2'b00, y}, {2'b00, tgt_reg[gi].cy}) < RAD);
        end
    endgenerate

    assign cand_x    = lfsr_q[9:0];
    assign cand_y    = lfsr_q[15:7];
    assign cand_ok   = (cand_x >= X_LO) && (cand_x < X_HI) && (cand_y >= Y_LO) && (cand_y < Y_HI);
    assign spawn_tgt = '{valid: 1'b1, cx: cand_x, cy: cand_y};

    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if (!tgt_reg[i].valid) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign spawn    = (state_reg == S_IDLE) && (cnt_reg == '0) && any_free && cand_ok;
    assign cur_tgt  = tgt_reg[idx_reg];
    assign scan_hit = cur_tgt.valid
                   && (abs_diff({1'b0, sx_reg}, {1'b0, cur_tgt.cx}) <= RAD)
                   && (abs_diff({2'b00, sy_reg}, {2'b00, cur_tgt.cy}) <= RAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            idx_reg    <= '0;
            sx_reg     <= '0;
            sy_reg     <= '0;
            score_reg  <= '0;
            cnt_reg    <= '0;
            hit_reg    <= 1'b0;
            miss_reg   <= 1'b0;
            render_reg <= 1'b0;
            for (int i = 0; i < N_TGT; i++) begin
                tgt_reg[i] <= '0;
            end
        end else begin
            hit_reg    <= 1'b0;
            miss_reg   <= 1'b0;
            render_reg <= |pix_in;
            if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
            // Spawn and shot acceptance share the idle edge; the scan sees the new slot.
            if (spawn) begin
                tgt_reg[free_idx] <= spawn_tgt;
            end
            case (state_reg)
                S_IDLE: begin
                    if (shot) begin
                        sx_reg    <= shoot_x;
                        sy_reg    <= shoot_y;
                        idx_reg   <= '0;
                        state_reg <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (scan_hit) begin
                        tgt_reg[idx_reg].valid <= 1'b0;
                        if (score_reg != {SCORE_W{1'b1}}) begin
                            score_reg <= score_reg + 1'b1;
                        end
                        hit_reg   <= 1'b1;
                        cnt_reg   <= CNT_W'(RESPAWN_TICKS);
                        state_reg <= S_IDLE;
                    end else if (idx_reg == IDX_W'(N_TGT - 1)) begin
                        miss_reg  <= 1'b1;
`ifdef TARGET_FIELD_MISS_PENALTY_EN
                        if (score_reg != '0) begin
                            score_reg <= score_reg - 1'b1;
                        end
`endif
                        state_reg <= S_IDLE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    assign render = render_reg;
    assign hit    = hit_reg;
    assign miss   = miss_reg;
    assign busy   = (state_reg == S_SCAN);
    assign score  = score_reg;
    assign dbg_x  = tgt_reg[dbg_sel].cx;
    assign dbg_y  = tgt_reg[dbg_sel].cy;

endmodule

// File: tb/tb_target_field.sv
// Bench for target_field: event-level model checked every cycle plus hand-computed directed checks.
module tb_target_field;

    localparam int N   = 4;
    localparam int R   = 16;
    localparam int SW  = 2;
    localparam int RT  = 100;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          shot;
    logic [9:0]    shoot_x;
    logic [8:0]    shoot_y;
    logic [9:0]    x;
    logic [8:0]    y;
    logic          render, hit, miss, busy;
    logic [SW-1:0] score;
    logic [N-1:0]  tgt_valid;
    logic [1:0]    dbg_sel;
    logic [9:0]    dbg_x;
    logic [8:0]    dbg_y;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: target set, score, pending scan outcome.
    int          m_cx [N];
    int          m_cy [N];
    bit          m_valid [N];
    logic [15:0] m_lfsr;
    int          m_score, m_end, m_slot, edge_no, m_spawn_ok;
    bit          m_busy, e_hit, e_miss, e_render;

    always #5 clk = ~clk;

    target_field #(
        .N_TGT         (N),
        .TGT_RADIUS    (R),
        .SCORE_W       (SW),
        .RESPAWN_TICKS (RT),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .shot      (shot),
        .shoot_x   (shoot_x),
        .shoot_y   (shoot_y),
        .x         (x),
        .y         (y),
        .render    (render),
        .hit       (hit),
        .miss      (miss),
        .busy      (busy),
        .score     (score),
        .tgt_valid (tgt_valid),
        .dbg_sel   (dbg_sel),
        .dbg_x     (dbg_x),
        .dbg_y     (dbg_y)
    );

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cx[i] = 0;
            m_cy[i] = 0;
            m_valid[i] = 0;
        end
        m_lfsr = 16'hACE1;
        m_score = 0;
        m_busy = 0;
        m_end = 0;
        m_slot = -1;
        edge_no = 0;
        m_spawn_ok = 0;
        e_hit = 0;
        e_miss = 0;
        e_render = 0;
    endtask

    // One active edge: spawn rule, shot outcome decided at acceptance, pulse at the scheduled edge.
    task automatic model_step();
        int cx, cy, j, k;
        bit was_busy;
        edge_no++;
        e_render = 0;
        for (int i = 0; i < N; i++)
            if (m_valid[i] && iabs(int'(x) - m_cx[i]) < R && iabs(int'(y) - m_cy[i]) < R)
                e_render = 1;
        e_hit = 0;
        e_miss = 0;
        was_busy = m_busy;
        cx = int'(m_lfsr & 16'h03FF);
        cy = int'(m_lfsr >> 7);
        if (!was_busy) begin
            if (edge_no >= m_spawn_ok && cx >= R && cx < 640 - R && cy >= R && cy < 480 - R) begin
                j = -1;
                for (int i = 0; i < N; i++)
                    if (j < 0 && !m_valid[i]) j = i;
                if (j >= 0) begin
                    m_valid[j] = 1;
                    m_cx[j] = cx;
                    m_cy[j] = cy;
                end
            end
            if (shot) begin
                k = -1;
                for (int i = 0; i < N; i++)
                    if (k < 0 && m_valid[i] && iabs(int'(shoot_x) - m_cx[i]) <= R
                        && iabs(int'(shoot_y) - m_cy[i]) <= R)
                        k = i;
                m_slot = k;
                m_busy = 1;
                m_end = edge_no + ((k >= 0) ? k + 1 : N);
            end
        end else if (edge_no == m_end) begin
            m_busy = 0;
            if (m_slot >= 0) begin
                m_valid[m_slot] = 0;
                if (m_score < SMAX) m_score++;
                e_hit = 1;
                m_spawn_ok = edge_no + RT + 1;
            end else begin
                e_miss = 1;
`ifdef TARGET_FIELD_MISS_PENALTY_EN
                if (m_score > 0) m_score--;
`endif
            end
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare process: every negedge, all outputs against the model.
    initial begin
        int vexp;
        @(posedge clk);
        forever begin
            @(negedge clk);
            vexp = 0;
            for (int i = 0; i < N; i++) vexp |= (int'(m_valid[i]) << i);
            chk("cyc_hit", hit, e_hit);
            chk("cyc_miss", miss, e_miss);
            chk("cyc_busy", busy, m_busy);
            chk("cyc_score", score, m_score);
            chk("cyc_valid", tgt_valid, vexp);
            chk("cyc_render", render, e_render);
            chk("cyc_dbg_x", dbg_x, m_cx[dbg_sel]);
            chk("cyc_dbg_y", dbg_y, m_cy[dbg_sel]);
        end
    end

    // Pixel sweep around the model's targets so render toggles on both sides of the edge.
    initial begin
        int cyc, j, xi, yi;
        cyc = 0;
        x = '0;
        y = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            j = cyc % N;
            xi = m_cx[j] + (cyc / 4) % 35 - 17;
            yi = m_cy[j] + (cyc / 5) % 35 - 17;
            if (xi < 0) xi = 0;
            if (yi < 0) yi = 0;
            if (yi > 479) yi = 479;
            x = 10'(xi);
            y = 9'(yi);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Shot at (fx,fy); optionally fire a second shot during the scan. Reports pulse latency.
    task automatic fire(input int fx, input int fy, input bit ig_en, input int ig_x, input int ig_y,
                        output int lat, output bit got_hit, output bit got_miss, output int busy_cyc);
        @(posedge clk);
        #1;
        shot = 1;
        shoot_x = 10'(fx);
        shoot_y = 9'(fy);
        @(posedge clk);
        #1;
        shot = 0;
        lat = 0;
        got_hit = 0;
        got_miss = 0;
        busy_cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 1 && ig_en) begin
                shot = 1;
                shoot_x = 10'(ig_x);
                shoot_y = 9'(ig_y);
            end
            if (i == 2) shot = 0;
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
            if (hit || miss) begin
                lat = i;
                got_hit = hit;
                got_miss = miss;
                break;
            end
        end
        shot = 0;
        $display("shot (%0d,%0d): latency=%0d hit=%0b miss=%0b busy=%0d score=%0d valid=%b",
                 fx, fy, lat, got_hit, got_miss, busy_cyc, score, tgt_valid);
    endtask

    task automatic wait_full(input int limit, output int cycles);
        cycles = 0;
        while (tgt_valid != 4'hF && cycles < limit) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic check_ranges(input string tag);
        for (int s = 0; s < N; s++) begin
            @(posedge clk);
            #1;
            dbg_sel = 2'(s);
            #1;
            chk({tag, "_x_range"}, int'(dbg_x >= 16 && dbg_x < 624), 1);
            chk({tag, "_y_range"}, int'(dbg_y >= 16 && dbg_y < 464), 1);
        end
    endtask

    initial begin
        int px[4];
        int py[4];
        int lat, bc, cyc, inv;
        bit gh, gm, seen;
        px = '{225, 451, 542, 60};
        py = '{345, 179, 412, 312};
        shot = 0;
        shoot_x = '0;
        shoot_y = '0;
        dbg_sel = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_score", score, 0);
        chk("rst_valid", tgt_valid, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1;

        wait_full(1000, cyc);
        $display("fill: all slots valid after %0d cycles", cyc);
        chk("fill_valid", tgt_valid, 15);
        check_ranges("fill");
        // First four in-range LFSR values from 16'hACE1, worked out by hand.
        for (int s = 0; s < N; s++) begin
            @(posedge clk);
            #1;
            dbg_sel = 2'(s);
            #1;
            chk("pin_dbg_x", dbg_x, px[s]);
            chk("pin_dbg_y", dbg_y, py[s]);
        end

        // Miss at (0,0) with a second shot aimed at slot 2 during the scan.
        fire(0, 0, 1'b1, 552, 402, lat, gh, gm, bc);
        chk("miss_latency", lat, 4);
        chk("miss_pulse", gm, 1);
        chk("miss_no_hit", gh, 0);
        chk("miss_busy_cycles", bc, 4);
        chk("miss_score", score, 0);
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (hit || miss || busy) seen = 1;
        end
        chk("ignored_shot", seen, 0);
        chk("miss_valid", tgt_valid, 15);

        fire(552, 402, 1'b0, 0, 0, lat, gh, gm, bc);
        chk("hit2_latency", lat, 3);
        chk("hit2_pulse", gh, 1);
        chk("hit2_busy_cycles", bc, 3);
        chk("hit2_score", score, 1);
        chk("hit2_valid", tgt_valid, 4'b1011);

        fire(225, 345, 1'b0, 0, 0, lat, gh, gm, bc);
        chk("hit0_latency", lat, 1);
        chk("hit0_score", score, 2);
        fire(451, 179, 1'b0, 0, 0, lat, gh, gm, bc);
        chk("hit1_latency", lat, 2);
        chk("hit1_score", score, 3);
        fire(60, 312, 1'b0, 0, 0, lat, gh, gm, bc);
        chk("hit3_latency", lat, 4);
        chk("sat_hit_pulse", gh, 1);
        chk("sat_score", score, 3);
        chk("all_cleared", tgt_valid, 0);

        inv = 0;
        while (tgt_valid == 0 && inv < 2000) begin
            @(posedge clk);
            #1;
            inv++;
        end
        $display("respawn: first slot back after %0d cycles", inv);
        chk("respawn_delay_ge_100", int'(inv >= RT), 1);
        chk("respawn_occurred", int'(tgt_valid != 0), 1);
        wait_full(2000, cyc);
        chk("refill_valid", tgt_valid, 15);
        check_ranges("respawn");

        // Reset asserted while the scan is running.
        @(posedge clk);
        #1;
        shot = 1;
        shoot_x = 10'(m_cx[3]);
        shoot_y = 9'(m_cy[3]);
        @(posedge clk);
        #1;
        shot = 0;
        chk("midscan_busy", busy, 1);
        rst_n = 0;
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (hit || miss) seen = 1;
        end
        $display("mid-scan reset: pulse_seen=%0b score=%0d valid=%b", seen, score, tgt_valid);
        chk("midscan_no_pulse", seen, 0);
        chk("midscan_score", score, 0);
        chk("midscan_valid", tgt_valid, 0);
        chk("midscan_busy_clear", busy, 0);
        rst_n = 1;
        repeat (10) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
